// File: rtl/bus_cdc_pkg.sv
// bus_cdc_pkg: shared FSM states, default sizes and pointer-width helper for the bus CDC sender
package bus_cdc_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} stateT;
  localparam int DEF_SIZE = 8;
  localparam int DEF_DEPTH = 4;
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/bus_cdc_fifo.sv
// bus_cdc_fifo: synchronous FIFO with registered occupancy count and head-of-queue output
module bus_cdc_fifo
  import bus_cdc_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [SIZE-1:0] wrData,
  output logic            full,
  output logic            empty,
  output logic [SIZE-1:0] headData
);
  localparam int PW = ptrWidth(DEPTH);
  logic [SIZE-1:0] mem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [PW:0] count;
  logic doPush, doPop;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign doPush = push && !full;
  assign doPop = pop && !empty;
  assign headData = mem[rdPtr];
  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop) rdPtr <= rdPtr + PW'(1);
      count <= count + (PW+1)'(doPush) - (PW+1)'(doPop);
    end
  end
  // Storage needs no reset; only entries covered by the count are ever read
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end
endmodule

// File: rtl/bus_cdc_sender.sv
// bus_cdc_sender: buffers upstream words and launches them one at a time into the toggle-handshake crossing
module bus_cdc_sender
  import bus_cdc_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_data,
  output logic             flag_out,
  input  logic             busy_in,
  output logic [SIZE-1:0]  bus_out,
  output logic             idle,
  output logic             err,
  output logic [CNT_W-1:0] sent_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  stateT state, stateNext;
  logic full, empty, pop, flagNext, errNext;
  logic [SIZE-1:0] headData, busNext;
  logic [CNT_W-1:0] cntNext;
  logic [TW-1:0] toCnt, toNext;
  assign in_ready = !full;
  assign idle = (state == IDLE) && empty;
  bus_cdc_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid && in_ready),
    .pop(pop),
    .wrData(in_data),
    .full(full),
    .empty(empty),
    .headData(headData)
  );
  // State and output registers; bus_out holds the last launched word until the next launch
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus_out <= '0;
      flag_out <= 1'b0;
      sent_count <= '0;
      err <= 1'b0;
      toCnt <= '0;
    end else begin
      state <= stateNext;
      bus_out <= busNext;
      flag_out <= flagNext;
      sent_count <= cntNext;
      err <= errNext;
      toCnt <= toNext;
    end
  end
  // Launch only from IDLE with busy low, then follow busy through one full round-trip
  always_comb begin
    stateNext = state;
    busNext = bus_out;
    flagNext = 1'b0;
    cntNext = sent_count;
    errNext = err;
    toNext = toCnt;
    pop = 1'b0;
    unique case (state)
      IDLE: if (!empty && !busy_in) begin
        pop = 1'b1;
        busNext = headData;
        flagNext = 1'b1;
        cntNext = sent_count + CNT_W'(1);
        stateNext = SEND;
      end
      SEND: begin
        toNext = '0;
        stateNext = WAIT_HI;
      end
      WAIT_HI: if (busy_in) stateNext = WAIT_LO;
      else begin
        toNext = toCnt + TW'(1);
        if (toNext == TW'(TIMEOUT)) begin
          errNext = 1'b1;
          stateNext = IDLE;
        end
      end
      WAIT_LO: if (!busy_in) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bus_cdc_sender.sv
// tb_bus_cdc_sender: table-driven and directed-sequence checks of bus_cdc_sender against a simple crossing model
module tb_bus_cdc_sender;
  logic clk, rst, in_valid, in_ready, flag_out, busy_in, idle, err;
  logic [7:0] in_data, bus_out;
  logic [3:0] sent_count;
  logic modelOn, busyForce, busyModel;
  int riseDly, holdCyc, riseCnt, holdCnt;
  int nCmp, nErr, nLaunch, flagBusyHits, wideFlagHits, base, base2;
  logic prevFlag, sawFull;
  logic [7:0] launched [256];

  typedef struct {
    logic r; logic v; logic [7:0] d; logic b;
    logic f; logic [7:0] bus; logic rdy; logic idl; logic [3:0] cnt; logic e;
  } vecT;
  vecT vt [22];

  assign busy_in = modelOn ? busyModel : busyForce;

  bus_cdc_sender #(.SIZE(8), .DEPTH(4), .CNT_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flag_out(flag_out), .busy_in(busy_in), .bus_out(bus_out), .idle(idle), .err(err),
    .sent_count(sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Crossing model: busy rises riseDly cycles after a flag and stays high holdCyc cycles
  initial begin
    busyModel = 1'b0;
    riseCnt = 0;
    holdCnt = 0;
  end
  always @(negedge clk) begin
    if (rst) begin
      busyModel = 1'b0;
      riseCnt = 0;
      holdCnt = 0;
    end else if (riseCnt > 0) begin
      riseCnt--;
      if (riseCnt == 0) begin
        busyModel = 1'b1;
        holdCnt = holdCyc;
      end
    end else if (holdCnt > 0) begin
      holdCnt--;
      if (holdCnt == 0) busyModel = 1'b0;
    end else if (flag_out) riseCnt = riseDly;
  end

  // Launch recorder: logs launched words, flags seen during busy, and flags wider than one cycle
  initial begin
    nLaunch = 0;
    flagBusyHits = 0;
    wideFlagHits = 0;
    prevFlag = 1'b0;
  end
  always @(negedge clk) begin
    if (flag_out) begin
      launched[nLaunch % 256] = bus_out;
      nLaunch++;
      if (busy_in) flagBusyHits++;
      if (prevFlag) wideFlagHits++;
    end
    prevFlag = flag_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pushWord(input logic [7:0] w);
    int g = 0;
    in_valid = 1'b1;
    in_data = w;
    while (!in_ready && g < 300) begin
      sawFull = 1'b1;
      tick();
      g++;
    end
    chk("push_ready_bound", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitIdle(input int maxCyc);
    int g = 0;
    while (!idle && g < maxCyc) begin
      tick();
      g++;
    end
    chk("wait_idle_bound", 32'(idle), 32'd1);
  endtask

  initial begin
    nCmp = 0;
    nErr = 0;
    sawFull = 1'b0;
    modelOn = 1'b0;
    busyForce = 1'b0;
    riseDly = 1;
    holdCyc = 4;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    //            r  v  d      b   f  bus    rdy idl cnt  e
    vt[0]  = '{1, 0, 8'h00, 0,  0, 8'h00, 1, 1, 4'd0, 0};
    vt[1]  = '{0, 1, 8'hA5, 0,  0, 8'h00, 1, 0, 4'd0, 0};
    vt[2]  = '{0, 0, 8'h00, 0,  1, 8'hA5, 1, 0, 4'd1, 0};
    vt[3]  = '{0, 0, 8'h00, 0,  0, 8'hA5, 1, 0, 4'd1, 0};
    vt[4]  = '{0, 0, 8'h00, 1,  0, 8'hA5, 1, 0, 4'd1, 0};
    vt[5]  = '{0, 0, 8'h00, 1,  0, 8'hA5, 1, 0, 4'd1, 0};
    vt[6]  = '{0, 0, 8'h00, 0,  0, 8'hA5, 1, 1, 4'd1, 0};
    vt[7]  = '{0, 1, 8'h3C, 1,  0, 8'hA5, 1, 0, 4'd1, 0};
    vt[8]  = '{0, 0, 8'h00, 1,  0, 8'hA5, 1, 0, 4'd1, 0};
    vt[9]  = '{0, 0, 8'h00, 1,  0, 8'hA5, 1, 0, 4'd1, 0};
    vt[10] = '{0, 0, 8'h00, 0,  1, 8'h3C, 1, 0, 4'd2, 0};
    vt[11] = '{0, 0, 8'h00, 0,  0, 8'h3C, 1, 0, 4'd2, 0};
    vt[12] = '{0, 0, 8'h00, 1,  0, 8'h3C, 1, 0, 4'd2, 0};
    vt[13] = '{0, 0, 8'h00, 0,  0, 8'h3C, 1, 1, 4'd2, 0};
    vt[14] = '{0, 1, 8'h11, 1,  0, 8'h3C, 1, 0, 4'd2, 0};
    vt[15] = '{0, 1, 8'h22, 1,  0, 8'h3C, 1, 0, 4'd2, 0};
    vt[16] = '{0, 1, 8'h33, 1,  0, 8'h3C, 1, 0, 4'd2, 0};
    vt[17] = '{0, 1, 8'h44, 1,  0, 8'h3C, 0, 0, 4'd2, 0};
    vt[18] = '{0, 1, 8'h55, 1,  0, 8'h3C, 0, 0, 4'd2, 0};
    vt[19] = '{0, 0, 8'h00, 0,  1, 8'h11, 1, 0, 4'd3, 0};
    vt[20] = '{0, 0, 8'h00, 0,  0, 8'h11, 1, 0, 4'd3, 0};
    vt[21] = '{1, 0, 8'h00, 0,  0, 8'h00, 1, 1, 4'd0, 0};
    for (int i = 0; i < 22; i++) begin
      rst = vt[i].r;
      in_valid = vt[i].v;
      in_data = vt[i].d;
      busyForce = vt[i].b;
      tick();
      chk($sformatf("vec%0d_flag", i), 32'(flag_out), 32'(vt[i].f));
      chk($sformatf("vec%0d_bus", i), 32'(bus_out), 32'(vt[i].bus));
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vt[i].rdy));
      chk($sformatf("vec%0d_idle", i), 32'(idle), 32'(vt[i].idl));
      chk($sformatf("vec%0d_count", i), 32'(sent_count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].e));
    end
    rst = 1'b0;
    in_valid = 1'b0;
    busyForce = 1'b0;

    // Single word through the crossing model
    modelOn = 1'b1;
    riseDly = 1;
    holdCyc = 4;
    doReset();
    base = nLaunch;
    in_valid = 1'b1;
    in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("single_flag_E0", 32'(flag_out), 32'd0);
    tick();
    chk("single_flag_E1", 32'(flag_out), 32'd1);
    tick();
    chk("single_flag_E2", 32'(flag_out), 32'd0);
    tick();
    chk("single_busy_up", 32'(busy_in), 32'd1);
    chk("single_bus_busy", 32'(bus_out), 32'hA5);
    waitIdle(50);
    chk("single_count", 32'(sent_count), 32'd1);
    chk("single_launches", 32'(nLaunch - base), 32'd1);
    chk("single_word", 32'(launched[base % 256]), 32'hA5);

    // Burst of six against a slow crossing
    holdCyc = 10;
    doReset();
    base = nLaunch;
    sawFull = 1'b0;
    for (int w = 1; w <= 6; w++) pushWord(8'(w));
    waitIdle(400);
    chk("burst_saw_full", 32'(sawFull), 32'd1);
    chk("burst_launches", 32'(nLaunch - base), 32'd6);
    for (int k = 0; k < 6; k++) chk($sformatf("burst_word%0d", k), 32'(launched[(base + k) % 256]), 32'(k + 1));
    chk("burst_count", 32'(sent_count), 32'd6);
    chk("burst_err", 32'(err), 32'd0);

    // Residual busy from reset, then a timeout because busy never rises
    modelOn = 1'b0;
    busyForce = 1'b1;
    doReset();
    base = nLaunch;
    in_valid = 1'b1;
    in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    repeat (19) tick();
    chk("resid_no_launch", 32'(nLaunch - base), 32'd0);
    busyForce = 1'b0;
    tick();
    chk("resid_flag_after_drop", 32'(flag_out), 32'd1);
    chk("resid_bus", 32'(bus_out), 32'h77);
    repeat (15) tick();
    chk("timeout_err_before", 32'(err), 32'd0);
    tick();
    chk("timeout_err_set", 32'(err), 32'd1);
    chk("timeout_idle", 32'(idle), 32'd1);
    pushWord(8'h99);
    tick();
    chk("timeout_next_flag", 32'(flag_out), 32'd1);
    chk("timeout_next_bus", 32'(bus_out), 32'h99);
    chk("timeout_next_count", 32'(sent_count), 32'd2);
    chk("timeout_err_sticky", 32'(err), 32'd1);

    // Reset while in WAIT_LO with three words buffered
    modelOn = 1'b1;
    riseDly = 1;
    holdCyc = 10;
    doReset();
    base = nLaunch;
    pushWord(8'hA1);
    pushWord(8'hA2);
    pushWord(8'hA3);
    pushWord(8'hA4);
    tick();
    chk("midrst_busy_high", 32'(busy_in), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_idle", 32'(idle), 32'd1);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_count", 32'(sent_count), 32'd0);
    chk("midrst_flag", 32'(flag_out), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    base2 = nLaunch;
    repeat (40) tick();
    chk("midrst_no_relaunch", 32'(nLaunch - base2), 32'd0);
    chk("midrst_first_only", 32'(nLaunch - base), 32'd1);

    // Counter wrap with a 4-bit counter
    holdCyc = 2;
    doReset();
    base = nLaunch;
    for (int i = 0; i < 17; i++) pushWord(8'h80 + 8'(i));
    waitIdle(600);
    chk("wrap_count", 32'(sent_count), 32'd1);
    chk("wrap_launches", 32'(nLaunch - base), 32'd17);
    for (int k = 0; k < 17; k++) chk($sformatf("wrap_word%0d", k), 32'(launched[(base + k) % 256]), 32'h80 + 32'(k));

    chk("flag_during_busy", 32'(flagBusyHits), 32'd0);
    chk("flag_width", 32'(wideFlagHits), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
